// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package stream_demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        LOCKED
    } demux_state_t;

endpackage

// File: rtl/demux_out_fifo.sv
// Per-output FIFO of the demux. head shows the oldest entry, or the most
// recently popped entry once the FIFO has run empty (zero after reset).
module demux_out_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? hold_q : mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; count and hold_q
    // alone decide what is visible, so stale entries can never leak out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                hold_q <= mem[rd_ptr];
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer. The destination is sampled on the
// first beat of a packet and held until in_last; each output has its own FIFO.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_last,
    output logic [N_OUT-1:0]   out_valid,
    input  logic [N_OUT-1:0]   out_ready,
    output logic [N_OUT*W-1:0] out_data,
    output logic [N_OUT-1:0]   out_last
);

    demux_state_t     state;
    logic [SEL_W-1:0] route_q;
    logic [SEL_W-1:0] route;
    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] empty;
    logic [N_OUT-1:0] push;
    logic             accept;

    assign route    = (state == IDLE) ? in_sel : route_q;
    assign in_ready = !rst && !full[route];
    assign accept   = in_valid && in_ready;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        push        = '0;
        push[route] = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            route_q <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        route_q <= in_sel;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        logic [W:0] head;

        demux_out_fifo #(
            .WIDTH(W + 1),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[i]),
            .push_data({in_last, in_data}),
            .pop      (out_valid[i] && out_ready[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .head     (head)
        );

        assign out_valid[i]       = !empty[i];
        assign out_data[i*W +: W] = head[W-1:0];
        assign out_last[i]        = head[W];
    end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_stream_demux_1_4;
    import stream_demux_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_last;
    logic [N_OUT-1:0]   out_valid;
    logic [N_OUT-1:0]   out_ready;
    logic [N_OUT*W-1:0] out_data;
    logic [N_OUT-1:0]   out_last;

    always #5 clk = ~clk;

    stream_demux_1_4 #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    int checks = 0;
    int errors = 0;

    // Model: one queue of {last,data} per channel, plus packet routing state.
    logic [W:0]       mq [N_OUT][$];
    logic [W:0]       mlast [N_OUT];
    bit               m_idle;
    logic [SEL_W-1:0] m_lock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) begin
            mq[i].delete();
            mlast[i] = '0;
        end
        m_idle = 1'b1;
        m_lock = '0;
    endtask

    function automatic logic [SEL_W-1:0] model_route();
        return m_idle ? in_sel : m_lock;
    endfunction

    function automatic logic model_ready();
        return !rst && (mq[model_route()].size() < DEPTH);
    endfunction

    task automatic compare();
        logic [N_OUT-1:0]   ev;
        logic [N_OUT*W-1:0] ed;
        logic [N_OUT-1:0]   el;
        logic [W:0]         h;
        for (int i = 0; i < N_OUT; i++) begin
            ev[i] = (mq[i].size() != 0);
            h = ev[i] ? mq[i][0] : mlast[i];
            ed[i*W +: W] = h[W-1:0];
            el[i] = h[W];
        end
        check("in_ready", in_ready, model_ready());
        check("out_valid", out_valid, ev);
        check("out_data", out_data, ed);
        check("out_last", out_last, el);
    endtask

    task automatic model_update();
        logic [SEL_W-1:0] r;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        r   = model_route();
        acc = in_valid && (mq[r].size() < DEPTH);
        for (int i = 0; i < N_OUT; i++) begin
            if (mq[i].size() != 0 && out_ready[i]) mlast[i] = mq[i].pop_front();
        end
        if (acc) begin
            mq[r].push_back({in_last, in_data});
            if (m_idle && !in_last) begin
                m_idle = 1'b0;
                m_lock = in_sel;
            end else if (!m_idle && in_last) begin
                m_idle = 1'b1;
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
    task automatic step();
        #1 compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] ch(input int i);
        return out_data[i*W +: W];
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
        out_ready = 4'hF;
        model_reset();

        // 1: reset for two cycles, then release
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_in_ready", in_ready, 1'b1);

        // 2: single-beat packet to ch2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hA; in_last = 1'b1;
        step();
        check("t2_out_valid", out_valid, 4'b0100);
        check("t2_data", ch(2), 4'hA);
        check("t2_last", out_last[2], 1'b1);
        check("t2_idle", dut.state == IDLE, 1'b1);
        in_valid = 1'b0;
        step();

        // 3: route latched on the first beat, in_sel ignored afterwards
        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h1; in_last = 1'b0;
        step();
        check("t3_b1", ch(1), 4'h1);
        check("t3_no_ch3_a", out_valid[3], 1'b0);
        in_sel = 2'd3; in_data = 4'h2;
        step();
        check("t3_b2", ch(1), 4'h2);
        check("t3_no_ch3_b", out_valid[3], 1'b0);
        in_data = 4'h3; in_last = 1'b1;
        step();
        check("t3_b3", ch(1), 4'h3);
        check("t3_b3_last", out_last[1], 1'b1);
        check("t3_no_ch3_c", out_valid[3], 1'b0);
        in_valid = 1'b0;
        step();

        // 4: backpressure on ch0 with a 3-beat packet
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_last = 1'b0; in_data = 4'h5;
        step();
        in_data = 4'h6;
        step();
        in_data = 4'h7; in_last = 1'b1;
        #1;
        check("t4_full_ready", in_ready, 1'b0);
        check("t4_head5", ch(0), 4'h5);
        step();
        out_ready = 4'hF;
        #1;
        check("t4_no_push_on_pop", in_ready, 1'b0);
        step();
        check("t4_head6", ch(0), 4'h6);
        check("t4_space_ready", in_ready, 1'b1);
        step();
        check("t4_head7", ch(0), 4'h7);
        check("t4_last7", out_last[0], 1'b1);
        in_valid = 1'b0;
        step();

        // 5: ch0 full does not block a new packet to ch1
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_last = 1'b1; in_data = 4'h8;
        step();
        in_data = 4'h9;
        step();
        in_sel = 2'd1; in_data = 4'hB;
        #1;
        check("t5_ready_ch1", in_ready, 1'b1);
        step();
        check("t5_out_valid", out_valid, 4'b0011);
        check("t5_ch1", ch(1), 4'hB);
        check("t5_ch0_kept", ch(0), 4'h8);
        in_valid = 1'b0; out_ready = 4'hF;
        repeat (3) step();

        // 6: reset in the middle of a packet
        in_valid = 1'b1; in_sel = 2'd2; in_last = 1'b0; in_data = 4'hC;
        step();
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("t6_ready_in_rst", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 4'b0000);
        check("t6_idle", dut.state == IDLE, 1'b1);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hD; in_last = 1'b1;
        step();
        check("t6_ch0_valid", out_valid, 4'b0001);
        check("t6_ch0_data", ch(0), 4'hD);
        in_valid = 1'b0;
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SEL_W'($urandom);
            in_data   = W'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = N_OUT'($urandom) | N_OUT'($urandom);
            step();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
        repeat (DEPTH + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
